// File: rtl/bf_pkg.sv
// Shared defaults and host FSM encoding for the bloom-filter bitmap controller.
package bf_pkg;

    localparam int unsigned BfAddrW = 13;
    localparam int unsigned BfNReq  = 4;
    localparam int unsigned BfIdW   = 2;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StClear = 2'd1,
        StReady = 2'd2
    } host_state_e;

endpackage

// File: rtl/ram_module.sv
// Dual-port synchronous RAM with registered port B read data; port A is write-only.
module ram_module #(
    parameter int unsigned DATA = 1,
    parameter int unsigned ADDR = 13
) (
    input  logic            clk_i,
    input  logic            a_we_i,
    input  logic [ADDR-1:0] a_addr_i,
    input  logic [DATA-1:0] a_din_i,
    input  logic            b_we_i,
    input  logic [ADDR-1:0] b_addr_i,
    input  logic [DATA-1:0] b_din_i,
    output logic [DATA-1:0] b_dout_o
);

    logic [DATA-1:0] mem [2**ADDR];

    // Single process keeps both write ports on one driver; port B reads old data.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem[a_addr_i] <= a_din_i;
        end
        if (b_we_i) begin
            mem[b_addr_i] <= b_din_i;
        end
        b_dout_o <= mem[b_addr_i];
    end

endmodule

// File: rtl/rr_arb.sv
// Round-robin arbiter: picks the first request at or after the pointer; hold suppresses the grant.
module rr_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            hold_i,
    output logic            sel_valid_o,
    output logic [IDW-1:0]  sel_idx_o,
    output logic [NREQ-1:0] gnt_o
);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] cand;
    logic           grant;

    always_comb begin
        sel_valid_o = 1'b0;
        sel_idx_o   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((int'(ptr_q) + i) % NREQ);
            if (!sel_valid_o && req_i[cand]) begin
                sel_valid_o = 1'b1;
                sel_idx_o   = cand;
            end
        end
    end

    assign grant = sel_valid_o && !hold_i;
    assign gnt_o = grant ? (NREQ'(1) << sel_idx_o) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = (sel_idx_o == IDW'(NREQ - 1)) ? '0 : sel_idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bloom_ctrl.sv
// Bitmap pre-filter controller: host clear/load on port A, round-robin queries on port B.
module bloom_ctrl
    import bf_pkg::*;
#(
    parameter int unsigned ADDR = BfAddrW,
    parameter int unsigned NREQ = BfNReq,
    parameter int unsigned IDW  = BfIdW
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clr_start_i,
    output logic                 busy_o,
    input  logic                 ld_valid_i,
    input  logic [ADDR-1:0]      ld_addr_i,
    output logic                 ld_ready_o,
    input  logic [NREQ-1:0]      q_req_i,
    input  logic [NREQ*ADDR-1:0] q_addr_i,
    output logic [NREQ-1:0]      q_gnt_o,
    output logic                 r_valid_o,
    output logic [IDW-1:0]       r_id_o,
    output logic                 r_hit_o
);

    host_state_e     state_q, state_d;
    logic [ADDR-1:0] cnt_q, cnt_d;
    logic            r_valid_q;
    logic [IDW-1:0]  r_id_q;

    logic            ld_accept;
    logic            a_we;
    logic [ADDR-1:0] a_addr;
    logic [0:0]      a_din;
    logic [0:0]      b_dout;

    logic [ADDR-1:0] q_addr_arr [NREQ];
    logic [ADDR-1:0] sel_addr;
    logic            sel_valid;
    logic [IDW-1:0]  sel_idx;
    logic            arb_hold;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        busy_o     = 1'b0;
        ld_ready_o = 1'b0;
        ld_accept  = 1'b0;
        a_we       = 1'b0;
        a_addr     = ld_addr_i;
        a_din      = 1'b1;
        unique case (state_q)
            StIdle: begin
                if (clr_start_i) state_d = StClear;
            end
            StClear: begin
                busy_o = 1'b1;
                a_we   = 1'b1;
                a_addr = cnt_q;
                a_din  = 1'b0;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == '1) state_d = StReady;
            end
            StReady: begin
                ld_ready_o = 1'b1;
                // A clear request wins over a load offered in the same cycle.
                if (clr_start_i) begin
                    state_d = StClear;
                end else if (ld_valid_i) begin
                    ld_accept = 1'b1;
                    a_we      = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            q_addr_arr[i] = q_addr_i[i*ADDR +: ADDR];
        end
    end

    assign sel_addr = q_addr_arr[sel_idx];
    // Stall a query that targets the bit being loaded so its retry sees the new value.
    assign arb_hold = (state_q != StReady) || (ld_accept && (ld_addr_i == sel_addr));

    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (q_req_i),
        .hold_i      (arb_hold),
        .sel_valid_o (sel_valid),
        .sel_idx_o   (sel_idx),
        .gnt_o       (q_gnt_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
            r_id_q    <= '0;
        end else begin
            r_valid_q <= |q_gnt_o;
            if (|q_gnt_o) r_id_q <= sel_idx;
        end
    end

    ram_module #(
        .DATA (1),
        .ADDR (ADDR)
    ) u_ram (
        .clk_i    (clk_i),
        .a_we_i   (a_we),
        .a_addr_i (a_addr),
        .a_din_i  (a_din),
        .b_we_i   (1'b0),
        .b_addr_i (sel_addr),
        .b_din_i  (1'b0),
        .b_dout_o (b_dout)
    );

    assign r_valid_o = r_valid_q;
    assign r_id_o    = r_id_q;
    // RAM output register has no reset; gate it so r_hit reads 0 when no result is pending.
    assign r_hit_o   = b_dout[0] & r_valid_q;

endmodule

// File: tb/tb_bloom_ctrl.sv
// Directed bench for bloom_ctrl: clear timing, loads, round-robin order, collision stall, reset.
module tb_bloom_ctrl;

    localparam int ADDR = 13;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clr_start;
    logic                 busy;
    logic                 ld_valid;
    logic [ADDR-1:0]      ld_addr;
    logic                 ld_ready;
    logic [NREQ-1:0]      q_req;
    logic [NREQ*ADDR-1:0] q_addr;
    logic [NREQ-1:0]      q_gnt;
    logic                 r_valid;
    logic [IDW-1:0]       r_id;
    logic                 r_hit;

    int n_pass  = 0;
    int n_total = 0;
    int n_clr;
    bit gnt_seen;
    logic [0:0] exp_hit [NREQ];

    bloom_ctrl #(
        .ADDR (ADDR),
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clr_start_i (clr_start),
        .busy_o      (busy),
        .ld_valid_i  (ld_valid),
        .ld_addr_i   (ld_addr),
        .ld_ready_o  (ld_ready),
        .q_req_i     (q_req),
        .q_addr_i    (q_addr),
        .q_gnt_o     (q_gnt),
        .r_valid_o   (r_valid),
        .r_id_o      (r_id),
        .r_hit_o     (r_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_addr(input int i, input logic [ADDR-1:0] a);
        q_addr[i*ADDR +: ADDR] = a;
    endtask

    // Pulse clr_start, then count the cycles busy stays high (bounded).
    task automatic run_clear(output int n);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        n = 0;
        gnt_seen = 1'b0;
        while (busy && n < 10000) begin
            n++;
            if (q_gnt != '0) gnt_seen = 1'b1;
            tick();
        end
        settle();
    endtask

    initial begin
        rst       = 1'b1;
        clr_start = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        q_req     = '0;
        q_addr    = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_gnt", 32'(q_gnt), 0);
        check("rst_r_valid", 32'(r_valid), 0);
        check("rst_r_id", 32'(r_id), 0);
        check("rst_r_hit", 32'(r_hit), 0);
        rst = 1'b0;
        tick();

        // Query pending in IDLE and through CLEAR, granted first READY cycle
        q_req = 4'b0001;
        set_addr(0, 13'h0000);
        settle();
        check("idle_gnt", 32'(q_gnt), 0);
        check("idle_ld_ready", 32'(ld_ready), 0);
        run_clear(n_clr);
        check("clear_cycles", 32'(n_clr), 8192);
        check("clear_gnt_blocked", 32'(gnt_seen), 0);
        check("ready_ld_ready", 32'(ld_ready), 1);
        check("ready_first_gnt", 32'(q_gnt), 32'b0001);
        tick();
        q_req = '0;
        settle();
        check("q0000_valid", 32'(r_valid), 1);
        check("q0000_id", 32'(r_id), 0);
        check("q0000_hit", 32'(r_hit), 0);

        // 0x1FFF (req3) and 0x0A5A (req1), pointer now 1
        set_addr(1, 13'h0A5A);
        set_addr(3, 13'h1FFF);
        q_req = 4'b1010;
        settle();
        check("q0a5a_gnt", 32'(q_gnt), 32'b0010);
        tick();
        q_req = 4'b1000;
        settle();
        check("q0a5a_id", 32'(r_id), 1);
        check("q0a5a_hit", 32'(r_hit), 0);
        check("q1fff_gnt", 32'(q_gnt), 32'b1000);
        tick();
        q_req = '0;
        settle();
        check("q1fff_valid", 32'(r_valid), 1);
        check("q1fff_id", 32'(r_id), 3);
        check("q1fff_hit", 32'(r_hit), 0);

        // Load 0x0123, then req2 -> 0x0123 and req0 -> 0x0124
        ld_valid = 1'b1;
        ld_addr  = 13'h0123;
        tick();
        ld_valid = 1'b0;
        set_addr(0, 13'h0124);
        set_addr(2, 13'h0123);
        q_req = 4'b0101;
        settle();
        check("ld_gnt0", 32'(q_gnt), 32'b0001);
        tick();
        q_req = 4'b0100;
        settle();
        check("ld_r0_id", 32'(r_id), 0);
        check("ld_r0_hit", 32'(r_hit), 0);
        check("ld_gnt2", 32'(q_gnt), 32'b0100);
        tick();
        q_req = '0;
        settle();
        check("ld_r2_valid", 32'(r_valid), 1);
        check("ld_r2_id", 32'(r_id), 2);
        check("ld_r2_hit", 32'(r_hit), 1);

        // Bring pointer back to 0 via a single req3 grant
        set_addr(3, 13'h0123);
        q_req = 4'b1000;
        settle();
        check("wrap_gnt3", 32'(q_gnt), 32'b1000);
        tick();
        q_req = '0;
        settle();
        check("wrap_r3_hit", 32'(r_hit), 1);

        // All four requesting for 8 cycles from pointer 0
        set_addr(0, 13'h0123);
        set_addr(1, 13'h0124);
        set_addr(2, 13'h0777);
        set_addr(3, 13'h1FFF);
        exp_hit[0] = 1'b1;
        exp_hit[1] = 1'b0;
        exp_hit[2] = 1'b0;
        exp_hit[3] = 1'b0;
        q_req = 4'b1111;
        settle();
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rr_gnt%0d", k), 32'(q_gnt), 32'(1 << (k % 4)));
            if (k > 0) begin
                check($sformatf("rr_valid%0d", k), 32'(r_valid), 1);
                check($sformatf("rr_id%0d", k), 32'(r_id), 32'((k - 1) % 4));
                check($sformatf("rr_hit%0d", k), 32'(r_hit), 32'(exp_hit[(k - 1) % 4]));
            end
            tick();
        end
        q_req = '0;
        settle();
        check("rr_valid8", 32'(r_valid), 1);
        check("rr_id8", 32'(r_id), 3);
        check("rr_idle_gnt", 32'(q_gnt), 0);

        // Collision: load 0x0777 while req1 queries 0x0777
        set_addr(1, 13'h0777);
        q_req    = 4'b0010;
        ld_valid = 1'b1;
        ld_addr  = 13'h0777;
        settle();
        check("coll_gnt_stall", 32'(q_gnt), 0);
        tick();
        ld_valid = 1'b0;
        settle();
        check("coll_no_result", 32'(r_valid), 0);
        check("coll_gnt_retry", 32'(q_gnt), 32'b0010);
        tick();
        q_req = '0;
        settle();
        check("coll_valid", 32'(r_valid), 1);
        check("coll_id", 32'(r_id), 1);
        check("coll_hit", 32'(r_hit), 1);

        // Load and query at different addresses proceed together
        set_addr(2, 13'h0801);
        q_req    = 4'b0100;
        ld_valid = 1'b1;
        ld_addr  = 13'h0800;
        settle();
        check("par_gnt", 32'(q_gnt), 32'b0100);
        tick();
        ld_valid = 1'b0;
        set_addr(2, 13'h0800);
        settle();
        check("par_r_hit", 32'(r_hit), 0);
        check("par_gnt_next", 32'(q_gnt), 32'b0100);
        tick();
        q_req = '0;
        settle();
        check("par_ld_visible", 32'(r_hit), 1);

        // clr_start beats a same-cycle load; reset at clear cycle 100
        clr_start = 1'b1;
        ld_valid  = 1'b1;
        ld_addr   = 13'h0999;
        settle();
        check("prio_ld_ready", 32'(ld_ready), 1);
        tick();
        clr_start = 1'b0;
        ld_valid  = 1'b0;
        settle();
        check("prio_busy", 32'(busy), 1);
        check("prio_ld_ready_low", 32'(ld_ready), 0);
        for (int c = 1; c < 100; c++) tick();
        check("mid_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ld_ready", 32'(ld_ready), 0);
        check("mid_rst_r_valid", 32'(r_valid), 0);
        tick();
        rst = 1'b0;
        tick();
        run_clear(n_clr);
        check("reclear_cycles", 32'(n_clr), 8192);
        check("reclear_ld_ready", 32'(ld_ready), 1);
        set_addr(0, 13'h0999);
        q_req = 4'b0001;
        settle();
        check("post_gnt0", 32'(q_gnt), 32'b0001);
        tick();
        set_addr(1, 13'h0777);
        q_req = 4'b0010;
        settle();
        check("post_0999_hit", 32'(r_hit), 0);
        check("post_gnt1", 32'(q_gnt), 32'b0010);
        tick();
        q_req = '0;
        settle();
        check("post_0777_valid", 32'(r_valid), 1);
        check("post_0777_hit", 32'(r_hit), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bloom_ctrl.md
Name: bloom_ctrl

Overview:
- Controller for the 1-bit-wide, 2^ADDR-deep dual-port bitmap RAM used as the target-hash pre-filter.
- Port A is owned by the host side. It runs a full-memory clear sequence and single-bit loads of target-hash indices.
- Port B is shared round-robin among NREQ cracker cores. Each core submits a hash index and gets a 1-bit hit/miss answer tagged with its requester ID.
- Sits between the host loader and the cracker core array, one per bitmap.

Parameters:
- ADDR, 13, bitmap address width (2^ADDR bits of storage).
- NREQ, 4, number of query requesters (2..16).
- IDW, 2, requester ID width; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock for host side, query side and RAM.
- rst  in  1  asynchronous, active-high reset.
- clr_start  in  1  pulse; begins full bitmap clear.
- busy  out  1  high while the clear sequence runs.
- ld_valid  in  1  load request: set bit at ld_addr.
- ld_addr  in  ADDR  bit index to set.
- ld_ready  out  1  load accepted this cycle when ld_valid && ld_ready.
- q_req  in  NREQ  per-requester query request, held until granted.
- q_addr  in  NREQ*ADDR  flattened query indices; requester i uses bits [i*ADDR +: ADDR].
- q_gnt  out  NREQ  one-hot grant; at most one bit high per cycle.
- r_valid  out  1  query result valid.
- r_id  out  IDW  requester ID of the result.
- r_hit  out  1  bitmap bit value at the queried index.

Behaviour:
- Reset (async, rst=1): FSM to IDLE, busy=0, ld_ready=0, q_gnt=0, r_valid=0, r_id=0, r_hit=0, clear counter=0, round-robin pointer=0.
- Bitmap contents are undefined after reset. A clear is required before any query result is meaningful.
- Host FSM states:
  - IDLE: ld_ready=0; queries blocked. clr_start -> CLEAR.
  - CLEAR: port A writes 0 at counter address, counter +1 per cycle.
    - busy=1 on every cycle in CLEAR.
    - After writing address 2^ADDR-1 -> READY. The clear takes exactly 2^ADDR cycles; the counter wraps to 0 on exit.
    - clr_start ignored while in CLEAR.
  - READY: ld_ready=1; queries enabled.
    - A load handshake writes 1 at ld_addr on port A in the same cycle.
    - clr_start -> CLEAR and takes priority over a same-cycle load, which is not accepted (ld_ready is registered low next cycle). In-flight query results still complete.
- Query arbiter (READY only; in IDLE/CLEAR q_gnt=0 and q_req stays pending):
  - Each cycle, pick the first requester with q_req=1 at or after the pointer (round-robin).
  - Assert q_gnt combinationally in that cycle and drive port B address from that requester's q_addr.
  - Pointer becomes winner+1 mod NREQ after each grant; unchanged if no grant.
  - The requester deasserts q_req or presents its next query on the cycle after its grant.
- Result latency: registered; RAM read data is registered.
  - r_valid=1, r_id=winner, r_hit=RAM dout on the cycle after the grant.
  - Back-to-back grants give one result per cycle, no gaps.
- Collision rule:
  - If an accepted load and the selected query have the same address in the same cycle, the query is not granted that cycle.
  - The pointer is held and the requester is retried next cycle, so it observes the new bit.
  - Different addresses proceed in parallel.
- A load is visible to any query granted on the cycle after the load handshake or later.
- Reset mid-CLEAR or mid-query: immediate return to IDLE. Pending r_valid is dropped and the partially cleared bitmap is undefined.

Decomposition:
- Shared package (bf_pkg):
  - ADDR/NREQ defaults.
  - Host FSM state encoding: IDLE=2'd0, CLEAR=2'd1, READY=2'd2.
- One natural sub-module, rr_arb: a NREQ-way round-robin arbiter with a hold input for the collision stall. It outputs one-hot grant and encoded index.
- RAM: instantiate ram_module with DATA=1 and ADDR=ADDR, both ports clocked by clk. Port B write is tied to 0.

Test Plan:
- Reset, pulse clr_start -> busy=1 for exactly 8192 cycles, then ld_ready=1. A query to any of addresses 0x0000, 0x1FFF, 0x0A5A returns r_hit=0.
- After clear, load 0x0123, then requester 2 queries 0x0123 and requester 0 queries 0x0124 -> results (id 2, hit 1) and (id 0, hit 0), each one cycle after its grant.
- All 4 q_req held high for 8 cycles from pointer 0 -> grant order 0,1,2,3,0,1,2,3 and r_valid high for 8 consecutive cycles.
- Load of 0x0777 in the same cycle as requester 1's only query of 0x0777 -> q_gnt=0 that cycle. Grant next cycle, result r_hit=1.
- Query raised during IDLE or CLEAR -> q_gnt stays 0 until READY, then granted first cycle of READY.
- Assert rst at clear cycle 100 -> busy=0 immediately, ld_ready=0, no r_valid. A new clr_start runs a full 8192-cycle clear.
